// File: rtl/data_mem_ctrl.sv
// MEM-stage data access responder: sequences multi-cycle transactions on the
// external data SRAM (Ram1) and the UART sharing its data bus, stalling the pipeline meanwhile.
module data_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] address,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        mem_stall,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_dq_out,
  output logic        ram_dq_oe,
  input  logic [15:0] ram_dq_in,
  output logic        ram_en_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_data_ready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned RAM_ADDR_W = 18;
  localparam int unsigned BYTE_W     = 8;

  localparam logic [ADDR_W-1:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [ADDR_W-1:0] UART_STAT_ADDR = 16'hBF01;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD1,
    S_RD2,
    S_WR1,
    S_WR2,
    S_UW1,
    S_UW2,
    S_UWAIT,
    S_UR1,
    S_UR2,
    S_DONE
  } state_t;

  state_t state, state_d;

  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     read_data_d;
  logic [RAM_ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0]     ram_dq_out_d;
  logic                  ram_dq_oe_d;
  logic                  ram_en_n_d;
  logic                  ram_oe_n_d;
  logic                  ram_we_n_d;
  logic                  uart_rdn_d;
  logic                  uart_wrn_d;

  logic req;
  logic is_uart_data;
  logic is_uart_stat;
  logic tx_idle;

  assign req          = mem_read | mem_write;
  assign is_uart_data = (address == UART_DATA_ADDR);
  assign is_uart_stat = (address == UART_STAT_ADDR);
  assign tx_idle      = uart_tbre & uart_tsre;

  assign mem_stall = req & (state != S_DONE) & ~rst;

  // Next state, latched request fields and load data
  always_comb begin
    state_d     = state;
    wdata_d     = wdata_q;
    read_data_d = read_data;
    ram_addr_d  = ram_addr;

    case (state)
      S_IDLE: begin
        if (req) begin
          ram_addr_d = {2'b00, address};
          wdata_d    = write_data;
          if (is_uart_stat) begin
            state_d = S_DONE;
            if (!mem_write) begin
              read_data_d = DATA_W'({uart_data_ready, tx_idle});
            end
          end else if (is_uart_data) begin
            state_d = mem_write ? S_UW1 : S_UR1;
          end else begin
            state_d = mem_write ? S_WR1 : S_RD1;
          end
        end
      end
      S_RD1: state_d = S_RD2;
      S_RD2: begin
        read_data_d = ram_dq_in;
        state_d     = S_DONE;
      end
      S_WR1: state_d = S_WR2;
      S_WR2: state_d = S_DONE;
      S_UW1: state_d = S_UW2;
      S_UW2: state_d = S_UWAIT;
      S_UWAIT: begin
        if (tx_idle) begin
          state_d = S_DONE;
        end
      end
      S_UR1: state_d = S_UR2;
      S_UR2: begin
        read_data_d = {8'h00, ram_dq_in[BYTE_W-1:0]};
        state_d     = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus strobes decoded from the state being entered, so the registered
  // outputs are valid throughout that state
  always_comb begin
    ram_en_n_d   = 1'b1;
    ram_oe_n_d   = 1'b1;
    ram_we_n_d   = 1'b1;
    uart_rdn_d   = 1'b1;
    uart_wrn_d   = 1'b1;
    ram_dq_oe_d  = 1'b0;
    ram_dq_out_d = '0;

    case (state_d)
      S_RD1, S_RD2: begin
        ram_en_n_d = 1'b0;
        ram_oe_n_d = 1'b0;
      end
      S_WR1: begin
        ram_en_n_d   = 1'b0;
        ram_we_n_d   = 1'b0;
        ram_dq_oe_d  = 1'b1;
        ram_dq_out_d = wdata_d;
      end
      S_WR2: begin
        ram_en_n_d   = 1'b0;
        ram_dq_oe_d  = 1'b1;
        ram_dq_out_d = wdata_d;
      end
      S_UW1: begin
        uart_wrn_d   = 1'b0;
        ram_dq_oe_d  = 1'b1;
        ram_dq_out_d = {8'h00, wdata_d[BYTE_W-1:0]};
      end
      S_UW2: begin
        ram_dq_oe_d  = 1'b1;
        ram_dq_out_d = {8'h00, wdata_d[BYTE_W-1:0]};
      end
      S_UR1, S_UR2: begin
        uart_rdn_d = 1'b0;
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wdata_q    <= '0;
      read_data  <= '0;
      ram_addr   <= '0;
      ram_dq_out <= '0;
      ram_dq_oe  <= 1'b0;
      ram_en_n   <= 1'b1;
      ram_oe_n   <= 1'b1;
      ram_we_n   <= 1'b1;
      uart_rdn   <= 1'b1;
      uart_wrn   <= 1'b1;
    end else begin
      state      <= state_d;
      wdata_q    <= wdata_d;
      read_data  <= read_data_d;
      ram_addr   <= ram_addr_d;
      ram_dq_out <= ram_dq_out_d;
      ram_dq_oe  <= ram_dq_oe_d;
      ram_en_n   <= ram_en_n_d;
      ram_oe_n   <= ram_oe_n_d;
      ram_we_n   <= ram_we_n_d;
      uart_rdn   <= uart_rdn_d;
      uart_wrn   <= uart_wrn_d;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: directed requests push expected DONE-cycle
// results; a negedge monitor accumulates per-transaction bus activity and checks it.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] address;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_stall;
  logic [17:0] ram_addr;
  logic [15:0] ram_dq_out;
  logic        ram_dq_oe;
  logic [15:0] ram_dq_in;
  logic        ram_en_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic        uart_rdn;
  logic        uart_wrn;
  logic        uart_data_ready;
  logic        uart_tbre;
  logic        uart_tsre;

  logic [15:0] sram [0:65535];
  logic [15:0] uart_bus;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          stall;
    int          we;
    int          en;
    int          rdoe;
    int          dqoe;
    int          wrn;
    int          rdn;
    logic [15:0] rd;
    logic        chk_dq;
    logic [15:0] dq;
    int          gap;
  } exp_t;

  exp_t sb[$];

  data_mem_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .address         (address),
    .write_data      (write_data),
    .read_data       (read_data),
    .mem_stall       (mem_stall),
    .ram_addr        (ram_addr),
    .ram_dq_out      (ram_dq_out),
    .ram_dq_oe       (ram_dq_oe),
    .ram_dq_in       (ram_dq_in),
    .ram_en_n        (ram_en_n),
    .ram_oe_n        (ram_oe_n),
    .ram_we_n        (ram_we_n),
    .uart_rdn        (uart_rdn),
    .uart_wrn        (uart_wrn),
    .uart_data_ready (uart_data_ready),
    .uart_tbre       (uart_tbre),
    .uart_tsre       (uart_tsre)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus model: UART drives when read-strobed, SRAM when enabled and output-enabled
  assign ram_dq_in = !uart_rdn ? uart_bus :
                     (!ram_en_n && !ram_oe_n) ? sram[ram_addr[15:0]] : 16'h0000;

  always @(posedge ram_we_n) begin
    if (!ram_en_n && ram_dq_oe) sram[ram_addr[15:0]] = ram_dq_out;
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string n, input int st, input int we, input int en,
                              input int rdoe, input int dqoe, input int wrn, input int rdn,
                              input logic [15:0] rd, input logic chk_dq, input logic [15:0] dq,
                              input int gap);
    exp_t e;
    e.name = n; e.stall = st; e.we = we; e.en = en; e.rdoe = rdoe; e.dqoe = dqoe;
    e.wrn = wrn; e.rdn = rdn; e.rd = rd; e.chk_dq = chk_dq; e.dq = dq; e.gap = gap;
    return e;
  endfunction

  // Monitor: accumulate activity over stall cycles, check on the DONE cycle
  int cyc = 0, last_done = 0;
  int stall_c = 0, we_c = 0, en_c = 0, rdoe_c = 0, dqoe_c = 0, wrn_c = 0, rdn_c = 0;
  logic [15:0] wrn_dq = 16'h0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stall_c = 0; we_c = 0; en_c = 0; rdoe_c = 0; dqoe_c = 0; wrn_c = 0; rdn_c = 0;
    end else if (mem_read || mem_write) begin
      if (mem_stall) begin
        stall_c++;
        if (!ram_we_n)  we_c++;
        if (!ram_en_n)  en_c++;
        if (!ram_oe_n)  rdoe_c++;
        if (ram_dq_oe)  dqoe_c++;
        if (!uart_rdn)  rdn_c++;
        if (!uart_wrn) begin
          wrn_c++;
          wrn_dq = ram_dq_out;
        end
      end else if (sb.size() == 0) begin
        cmp("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        cmp({e.name, "_stall"}, stall_c, e.stall);
        cmp({e.name, "_we_low"}, we_c, e.we);
        cmp({e.name, "_en_low"}, en_c, e.en);
        cmp({e.name, "_oe_low"}, rdoe_c, e.rdoe);
        cmp({e.name, "_dq_oe"}, dqoe_c, e.dqoe);
        cmp({e.name, "_wrn_low"}, wrn_c, e.wrn);
        cmp({e.name, "_rdn_low"}, rdn_c, e.rdn);
        cmp({e.name, "_read_data"}, int'(read_data), int'(e.rd));
        if (e.chk_dq) cmp({e.name, "_uart_dq"}, int'(wrn_dq), int'(e.dq));
        if (e.gap != 0) cmp({e.name, "_gap"}, cyc - last_done, e.gap);
        last_done = cyc;
        stall_c = 0; we_c = 0; en_c = 0; rdoe_c = 0; dqoe_c = 0; wrn_c = 0; rdn_c = 0;
      end
    end
  end

  // Issue one request (called #1 after a posedge) and hold it until the DONE edge
  task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] d, input exp_t e);
    bit done;
    done = 0;
    sb.push_back(e);
    mem_read = rd; mem_write = wr; address = a; write_data = d;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!mem_stall) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      cmp({e.name, "_timeout"}, 1, 0);
      sb.delete();
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic chk_idle_bus(input string n);
    cmp({n, "_en_n"}, int'(ram_en_n), 1);
    cmp({n, "_oe_n"}, int'(ram_oe_n), 1);
    cmp({n, "_we_n"}, int'(ram_we_n), 1);
    cmp({n, "_rdn"},  int'(uart_rdn), 1);
    cmp({n, "_wrn"},  int'(uart_wrn), 1);
    cmp({n, "_dq_oe"}, int'(ram_dq_oe), 0);
    cmp({n, "_stall"}, int'(mem_stall), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    sram[1] = 16'hA001;
    sram[2] = 16'hB002;
    uart_bus = 16'h3C7E;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; address = '0; write_data = '0;
    uart_data_ready = 1'b0; uart_tbre = 1'b1; uart_tsre = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_bus("reset");
    cmp("reset_read_data", int'(read_data), 0);
    cmp("reset_ram_addr", int'(ram_addr), 0);
    cmp("reset_dq_out", int'(ram_dq_out), 0);
    rst = 1'b0;

    // SRAM write then read back
    issue(1'b0, 1'b1, 16'h0040, 16'h1234,
          mk("sram_wr", 3, 1, 2, 0, 2, 0, 0, 16'h0000, 1'b0, 16'h0, 0));
    issue(1'b1, 1'b0, 16'h0040, 16'h0000,
          mk("sram_rd", 3, 0, 2, 2, 0, 0, 0, 16'h1234, 1'b0, 16'h0, 0));

    // No request: block sits idle
    repeat (3) @(posedge clk);
    #1;
    chk_idle_bus("idle");

    // Back-to-back loads, second accepted right after DONE
    issue(1'b1, 1'b0, 16'h0001, 16'h0000,
          mk("b2b_rd1", 3, 0, 2, 2, 0, 0, 0, 16'hA001, 1'b0, 16'h0, 0));
    issue(1'b1, 1'b0, 16'h0002, 16'h0000,
          mk("b2b_rd2", 3, 0, 2, 2, 0, 0, 0, 16'hB002, 1'b0, 16'h0, 4));

    // UART write with transmitter busy for 5 UWAIT cycles
    uart_tsre = 1'b0;
    fork
      issue(1'b0, 1'b1, 16'hBF00, 16'h77A5,
            mk("uart_wr", 8, 0, 0, 0, 2, 1, 0, 16'hB002, 1'b1, 16'h00A5, 0));
      begin
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          if (!uart_wrn) break;
        end
        repeat (6) @(posedge clk);
        #1;
        uart_tsre = 1'b1;
      end
    join

    // Status read then UART data read
    uart_data_ready = 1'b1;
    issue(1'b1, 1'b0, 16'hBF01, 16'h0000,
          mk("status_rd", 1, 0, 0, 0, 0, 0, 0, 16'h0003, 1'b0, 16'h0, 0));
    issue(1'b1, 1'b0, 16'hBF00, 16'h0000,
          mk("uart_rd", 3, 0, 0, 0, 0, 0, 2, 16'h007E, 1'b0, 16'h0, 0));

    // Both request lines: write wins
    issue(1'b1, 1'b1, 16'h0010, 16'hBEEF,
          mk("rdwr_both", 3, 1, 2, 0, 2, 0, 0, 16'h007E, 1'b0, 16'h0, 0));
    cmp("rdwr_both_sram", int'(sram[16]), 16'hBEEF);

    // Write to status register is accepted and ignored
    issue(1'b0, 1'b1, 16'hBF01, 16'hFFFF,
          mk("status_wr", 1, 0, 0, 0, 0, 0, 0, 16'h007E, 1'b0, 16'h0, 0));

    // Reset during WR1
    mem_write = 1'b1; address = 16'h0020; write_data = 16'h5555;
    @(posedge clk); #1;
    cmp("rst_wr1_entered", int'(ram_we_n), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle_bus("rst_wr1");
    cmp("rst_wr1_read_data", int'(read_data), 0);
    cmp("rst_wr1_ram_addr", int'(ram_addr), 0);
    rst = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;

    // Back in IDLE: single-cycle status read, tsre low
    uart_data_ready = 1'b1; uart_tsre = 1'b0;
    issue(1'b1, 1'b0, 16'hBF01, 16'h0000,
          mk("post_rst_status", 1, 0, 0, 0, 0, 0, 0, 16'h0002, 1'b0, 16'h0, 0));

    repeat (3) @(posedge clk);
    #1;
    cmp("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Responder for the pipeline's MEM-stage data accesses. It replaces the single-cycle fake data memory. It accepts one read or write request at a time from the exe_mem register outputs. Each access runs as a multi-cycle transaction on the board's external data SRAM (Ram1) or on the UART that shares its data bus. While a transaction is in flight, `mem_stall` freezes the pipeline.

## Interface
- No parameters.
- `clk  in  1` — system clock; all state updates on rising edge.
- `rst  in  1` — synchronous, active-high reset.
- `mem_read  in  1` — MEM stage requests a load.
- `mem_write  in  1` — MEM stage requests a store; has priority if both are high.
- `address  in  16` — word address (ALU result).
- `write_data  in  16` — store data.
- `read_data  out  16` — load result, valid in the DONE cycle and held until the next load completes.
- `mem_stall  out  1` — combinational; high while a request is present and not yet completed.
- `ram_addr  out  18` — SRAM address, `{2'b00, address}`, latched at accept.
- `ram_dq_out  out  16` — bus drive value.
- `ram_dq_oe  out  1` — tri-state enable for `ram_dq_out`.
- `ram_dq_in  in  16` — bus sample value.
- `ram_en_n`, `ram_oe_n`, `ram_we_n`  `out  1` each — SRAM strobes, active low.
- `uart_rdn`, `uart_wrn`  `out  1` each — UART strobes, active low.
- `uart_data_ready`, `uart_tbre`, `uart_tsre`  `in  1` each — UART status inputs.

## Operation
- Address map:
  - 0xBF00 is UART data.
  - 0xBF01 is UART status.
  - Every other address goes to SRAM.
- States: IDLE, RD1, RD2, WR1, WR2, UW1, UW2, UWAIT, UR1, UR2, DONE.
- IDLE: on a request, latch address and write_data, then branch.
  - Status read or write to 0xBF01 → DONE.
  - SRAM read → RD1. SRAM write → WR1.
  - UART write → UW1. UART read → UR1.
- SRAM read:
  - RD1 and RD2 drive `ram_en_n=0` and `ram_oe_n=0`.
  - At the end of RD2, `read_data <= ram_dq_in`.
- SRAM write:
  - WR1: `ram_en_n=0`, `ram_we_n=0`, `ram_dq_oe=1`.
  - WR2: `ram_we_n=1`, while en and data are held.
- UART write:
  - UW1: `uart_wrn=0`, `ram_dq_oe=1`, `ram_dq_out={8'h00, data[7:0]}`.
  - UW2: `uart_wrn=1`, data still driven.
  - UWAIT: wait until `uart_tbre & uart_tsre`, then → DONE.
- UART read:
  - UR1 and UR2 drive `uart_rdn=0`.
  - At the end of UR2, `read_data <= {8'h00, ram_dq_in[7:0]}`.
  - Data-ready is not checked; software polls status first.
- Status read: `read_data <= {14'b0, uart_data_ready, uart_tbre & uart_tsre}`, latched on the IDLE→DONE edge.
- Writes to 0xBF01 are accepted and ignored.
- DONE: `mem_stall=0`, so the pipeline advances. Next state is IDLE unconditionally. A new request is accepted only from IDLE.
- `ram_en_n` is low only in RD1/RD2/WR1/WR2. During UART accesses `ram_en_n=1`, so the SRAM never contends with the UART.
- `ram_dq_oe` is high only in WR1, WR2, UW1, UW2.

## Timing
- `mem_stall = (mem_read | mem_write) & (state != DONE) & ~rst`.
- Stall cycles, counting the IDLE accept cycle:
  - Status: 1.
  - SRAM read or write: 3.
  - UART read: 3.
  - UART write: 3 + N, where N is the number of UWAIT cycles.
- Cycles with no request leave the block in IDLE with all strobes inactive.
- The pipeline holds its request inputs stable while stalled. The block uses only latched copies after accept.
- Reset values: state IDLE, `read_data=0`, `ram_addr=0`, `ram_dq_out=0`, `ram_dq_oe=0`, all `_n` strobes 1, `mem_stall=0`.
- Reset mid-transaction aborts it. Strobes and OE go inactive from the next edge. A partial SRAM write is permitted.

## Test plan
- SRAM write then read:
  - Stimulus: write 0x1234 to 0x0040, then read 0x0040 against an SRAM model.
  - Required: `mem_stall` high for exactly 3 cycles each; `ram_we_n` low for exactly 1 cycle; `read_data=0x1234` in DONE.
- Back-to-back loads:
  - Stimulus: read 0x0001 then 0x0002, with the pipeline advancing on DONE.
  - Required: the second request is accepted in the cycle after DONE, and the DONE values match the model.
- UART write with busy transmitter:
  - Stimulus: write 0x00A5 to 0xBF00; hold `tsre=0` for 5 cycles after UW2.
  - Required: `uart_wrn` low 1 cycle with `ram_dq_out=0x00A5`; total stall 8 cycles; `ram_en_n` stays 1.
- Status and UART read:
  - Stimulus: with `data_ready=1`, `tbre=tsre=1`, read 0xBF01, then read 0xBF00 with the bus model returning 0x3C7E.
  - Required: `read_data=0x0003` after 1 stall cycle; then `read_data=0x007E`.
- Simultaneous read and write:
  - Stimulus: both request lines high at 0x0010 with `write_data=0xBEEF`.
  - Required: the write path is taken and the SRAM model holds 0xBEEF.
- Reset in WR1:
  - Stimulus: assert `rst` during WR1.
  - Required: next cycle all strobes 1, `ram_dq_oe=0`, `mem_stall=0`, `read_data=0`, state IDLE.
